// File: rtl/axis_fft_config_sink.sv
// AXI4-Stream config sink for one FFT core: latches direction/scale words between
// frames and follows frame boundaries by watching the core's data-input handshake.
module axis_fft_config_sink #(
  parameter int              CFG_W     = 16,
  parameter int              FRAME_LEN = 512,
  parameter int              CNT_W     = 10,
  parameter logic [CFG_W-1:0] RESET_CFG = CFG_W'(16'h0001)
) (
  input  logic               aclk,
  input  logic               areset,
  input  logic [CFG_W-1:0]   s_axis_config_tdata,
  input  logic               s_axis_config_tvalid,
  output logic               s_axis_config_tready,
  input  logic               mon_tvalid,
  input  logic               mon_tready,
  input  logic               mon_tlast,
  output logic               cfg_fwd_inv,
  output logic [CFG_W-2:0]   cfg_scale_sch,
  output logic               cfg_update,
  output logic               frame_active,
  output logic               event_tlast_unexpected,
  output logic               event_tlast_missing,
  output logic [CNT_W-1:0]   frame_cnt
);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

  localparam logic [CNT_W:0] LP_LEN = (CNT_W+1)'(FRAME_LEN);

  state_t             r_state;
  logic [CFG_W-1:0]   r_cfg;
  logic               r_cfg_update;
  logic               r_ev_unexp;
  logic               r_ev_miss;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   r_frame_cnt;

  logic               w_beat;
  logic               w_cfg_hs;
  logic [CNT_W:0]     w_next_cnt;
  logic               w_len_hit;
  logic               w_end;

  assign s_axis_config_tready = (r_state == ST_IDLE) && !areset;
  assign w_beat     = mon_tvalid && mon_tready;
  assign w_cfg_hs   = s_axis_config_tvalid && s_axis_config_tready;
  // Beat counter is held at 0 in IDLE, so the same end test covers a frame's first beat.
  assign w_next_cnt = {1'b0, r_beat_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_len_hit  = (w_next_cnt == LP_LEN);
  assign w_end      = w_len_hit || mon_tlast;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_cfg        <= RESET_CFG;
      r_cfg_update <= 1'b0;
      r_ev_unexp   <= 1'b0;
      r_ev_miss    <= 1'b0;
      r_beat_cnt   <= '0;
      r_frame_cnt  <= '0;
    end else begin
      r_cfg_update <= w_cfg_hs;
      r_ev_unexp   <= 1'b0;
      r_ev_miss    <= 1'b0;
      if (w_cfg_hs) begin
        r_cfg <= s_axis_config_tdata;
      end
      if (w_beat) begin
        if (w_end) begin
          r_state     <= ST_IDLE;
          r_beat_cnt  <= '0;
          r_frame_cnt <= r_frame_cnt + CNT_W'(1);
          r_ev_unexp  <= mon_tlast && !w_len_hit;
          r_ev_miss   <= w_len_hit && !mon_tlast;
        end else begin
          r_state    <= ST_ACTIVE;
          r_beat_cnt <= w_next_cnt[CNT_W-1:0];
        end
      end
    end
  end

  assign cfg_fwd_inv            = r_cfg[0];
  assign cfg_scale_sch          = r_cfg[CFG_W-1:1];
  assign cfg_update             = r_cfg_update;
  assign frame_active           = (r_state == ST_ACTIVE);
  assign event_tlast_unexpected = r_ev_unexp;
  assign event_tlast_missing    = r_ev_miss;
  assign frame_cnt              = r_frame_cnt;

endmodule

// File: tb/tb_axis_fft_config_sink.sv
// Directed bench for axis_fft_config_sink: a FRAME_LEN=512 instance and a FRAME_LEN=1 instance.
module tb_axis_fft_config_sink;

  logic        aclk = 1'b0;
  logic        areset;
  logic [15:0] cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready;
  logic        mon_tvalid, mon_tready, mon_tlast;
  logic        fwd_inv;
  logic [14:0] scale_sch;
  logic        cfg_update, frame_active, ev_unexp, ev_miss;
  logic [9:0]  frame_cnt;

  logic [15:0] b_cfg_tdata;
  logic        b_cfg_tvalid, b_cfg_tready;
  logic        b_mon_tvalid, b_mon_tready, b_mon_tlast;
  logic        b_fwd_inv, b_cfg_update, b_frame_active, b_ev_unexp, b_ev_miss;
  logic [14:0] b_scale_sch;
  logic [9:0]  b_frame_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_unexp, n_miss, n_upd, miss_at, rdy_in_frame;
  logic act_first;

  always #5 aclk = ~aclk;

  axis_fft_config_sink #(.CFG_W(16), .FRAME_LEN(512), .CNT_W(10), .RESET_CFG(16'h0001)) u_dut (
    .aclk(aclk), .areset(areset),
    .s_axis_config_tdata(cfg_tdata), .s_axis_config_tvalid(cfg_tvalid),
    .s_axis_config_tready(cfg_tready),
    .mon_tvalid(mon_tvalid), .mon_tready(mon_tready), .mon_tlast(mon_tlast),
    .cfg_fwd_inv(fwd_inv), .cfg_scale_sch(scale_sch), .cfg_update(cfg_update),
    .frame_active(frame_active), .event_tlast_unexpected(ev_unexp),
    .event_tlast_missing(ev_miss), .frame_cnt(frame_cnt)
  );

  axis_fft_config_sink #(.CFG_W(16), .FRAME_LEN(1), .CNT_W(10), .RESET_CFG(16'h0001)) u_dut1 (
    .aclk(aclk), .areset(areset),
    .s_axis_config_tdata(b_cfg_tdata), .s_axis_config_tvalid(b_cfg_tvalid),
    .s_axis_config_tready(b_cfg_tready),
    .mon_tvalid(b_mon_tvalid), .mon_tready(b_mon_tready), .mon_tlast(b_mon_tlast),
    .cfg_fwd_inv(b_fwd_inv), .cfg_scale_sch(b_scale_sch), .cfg_update(b_cfg_update),
    .frame_active(b_frame_active), .event_tlast_unexpected(b_ev_unexp),
    .event_tlast_missing(b_ev_miss), .frame_cnt(b_frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drives n beats (optional tready gaps), tlast on beat tlast_at (0 = never),
  // presents a config word after beat cfg_at (0 = never) and tallies output pulses.
  task automatic run_beats(input int n, input int tlast_at, input bit gaps,
                           input int cfg_at, input logic [15:0] cfg_word);
    int   beats;
    int   guard;
    logic took;
    n_unexp = 0; n_miss = 0; n_upd = 0; miss_at = 0; rdy_in_frame = 0; act_first = 1'b0;
    beats = 0;
    guard = 0;
    while (beats < n && guard < 20000) begin
      mon_tvalid = 1'b1;
      mon_tready = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      mon_tlast  = (tlast_at != 0) && (beats + 1 == tlast_at);
      took = mon_tready;
      tick();
      guard++;
      if (took) beats++;
      if (took && cfg_at != 0 && beats == cfg_at) begin
        cfg_tvalid = 1'b1;
        cfg_tdata  = cfg_word;
      end
      if (ev_unexp) n_unexp++;
      if (ev_miss) begin n_miss++; miss_at = beats; end
      if (cfg_update) n_upd++;
      if (took && beats == 1) act_first = frame_active;
      if (beats < n && cfg_tready) rdy_in_frame++;
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
    chk("beats_done", beats, n);
  endtask

  initial begin
    int b_bad;
    areset = 1'b1;
    cfg_tdata = '0; cfg_tvalid = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; mon_tlast = 1'b0;
    b_cfg_tdata = '0; b_cfg_tvalid = 1'b0;
    b_mon_tvalid = 1'b0; b_mon_tready = 1'b0; b_mon_tlast = 1'b0;
    #1;
    chk("tready_in_reset", 32'(cfg_tready), 32'h0);
    tick(); tick();
    areset = 1'b0;
    tick();
    chk("rst_fwd_inv", 32'(fwd_inv), 32'h1);
    chk("rst_scale", 32'(scale_sch), 32'h0);
    chk("rst_tready", 32'(cfg_tready), 32'h1);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
    chk("rst_active", 32'(frame_active), 32'h0);
    chk("rst_update", 32'(cfg_update), 32'h0);

    // Single config words
    cfg_tvalid = 1'b1; cfg_tdata = 16'h0000;
    tick();
    cfg_tvalid = 1'b0;
    chk("cfg0_fwd", 32'(fwd_inv), 32'h0);
    chk("cfg0_update", 32'(cfg_update), 32'h1);
    tick();
    chk("cfg0_update_drop", 32'(cfg_update), 32'h0);
    cfg_tvalid = 1'b1; cfg_tdata = 16'h00AB;
    tick();
    cfg_tvalid = 1'b0;
    chk("cfgAB_scale", 32'(scale_sch), 32'h55);
    chk("cfgAB_fwd", 32'(fwd_inv), 32'h1);

    // Back-to-back config words
    cfg_tvalid = 1'b1; cfg_tdata = 16'h0002;
    tick();
    chk("b2b1_update", 32'(cfg_update), 32'h1);
    chk("b2b1_scale", 32'(scale_sch), 32'h1);
    chk("b2b1_fwd", 32'(fwd_inv), 32'h0);
    cfg_tdata = 16'h0007;
    tick();
    cfg_tvalid = 1'b0;
    chk("b2b2_update", 32'(cfg_update), 32'h1);
    chk("b2b2_scale", 32'(scale_sch), 32'h3);
    chk("b2b2_fwd", 32'(fwd_inv), 32'h1);
    tick();

    // Full frame with gaps; config presented at beat 10 must stall
    run_beats(512, 512, 1'b1, 10, 16'h0000);
    chk("f512_active_first", 32'(act_first), 32'h1);
    chk("f512_unexp", n_unexp, 0);
    chk("f512_miss", n_miss, 0);
    chk("f512_no_update", n_upd, 0);
    chk("f512_tready_stalled", rdy_in_frame, 0);
    chk("f512_frame_cnt", 32'(frame_cnt), 32'h1);
    chk("f512_active_end", 32'(frame_active), 32'h0);
    chk("f512_tready_end", 32'(cfg_tready), 32'h1);
    chk("f512_cfg_held", 32'(fwd_inv), 32'h1);
    tick();
    cfg_tvalid = 1'b0;
    chk("stall_cfg_fwd", 32'(fwd_inv), 32'h0);
    chk("stall_cfg_update", 32'(cfg_update), 32'h1);

    // Early tlast at beat 300
    run_beats(300, 300, 1'b0, 0, 16'h0);
    chk("t300_unexp", n_unexp, 1);
    chk("t300_miss", n_miss, 0);
    chk("t300_frame_cnt", 32'(frame_cnt), 32'h2);
    chk("t300_active", 32'(frame_active), 32'h0);

    // 512 beats without tlast
    run_beats(512, 0, 1'b1, 0, 16'h0);
    chk("nolast_miss", n_miss, 1);
    chk("nolast_miss_at", miss_at, 512);
    chk("nolast_unexp", n_unexp, 0);
    chk("nolast_frame_cnt", 32'(frame_cnt), 32'h3);
    tick();
    chk("nolast_miss_drop", 32'(ev_miss), 32'h0);

    // Config handshake and first beat on the same edge
    cfg_tvalid = 1'b1; cfg_tdata = 16'h0001;
    tick();
    cfg_tdata = 16'h0000;
    mon_tvalid = 1'b1; mon_tready = 1'b1; mon_tlast = 1'b0;
    tick();
    cfg_tvalid = 1'b0; mon_tvalid = 1'b0; mon_tready = 1'b0;
    chk("simul_fwd", 32'(fwd_inv), 32'h0);
    chk("simul_update", 32'(cfg_update), 32'h1);
    chk("simul_active", 32'(frame_active), 32'h1);
    chk("simul_tready", 32'(cfg_tready), 32'h0);
    run_beats(511, 511, 1'b1, 0, 16'h0);
    chk("simul_frame_cnt", 32'(frame_cnt), 32'h4);
    chk("simul_events", n_unexp + n_miss, 0);

    // tlast on a lone beat in IDLE
    run_beats(1, 1, 1'b0, 0, 16'h0);
    chk("idle_tlast_unexp", n_unexp, 1);
    chk("idle_tlast_cnt", 32'(frame_cnt), 32'h5);
    chk("idle_tlast_active", 32'(frame_active), 32'h0);

    // tvalid without tready is not a beat
    mon_tvalid = 1'b1; mon_tready = 1'b0; mon_tlast = 1'b1;
    tick(); tick(); tick();
    mon_tvalid = 1'b0; mon_tlast = 1'b0;
    chk("noready_cnt", 32'(frame_cnt), 32'h5);
    chk("noready_active", 32'(frame_active), 32'h0);
    chk("noready_events", 32'({ev_unexp, ev_miss}), 32'h0);

    // Reset mid-frame at beat 100
    run_beats(100, 0, 1'b0, 0, 16'h0);
    chk("mid_active", 32'(frame_active), 32'h1);
    areset = 1'b1;
    #1;
    chk("mid_rst_fwd", 32'(fwd_inv), 32'h1);
    chk("mid_rst_scale", 32'(scale_sch), 32'h0);
    chk("mid_rst_cnt", 32'(frame_cnt), 32'h0);
    chk("mid_rst_active", 32'(frame_active), 32'h0);
    chk("mid_rst_tready", 32'(cfg_tready), 32'h0);
    chk("mid_rst_events", 32'({ev_unexp, ev_miss, cfg_update}), 32'h0);
    tick();
    areset = 1'b0;
    tick();
    chk("post_rst_tready", 32'(cfg_tready), 32'h1);
    chk("post_rst_active", 32'(frame_active), 32'h0);

    // FRAME_LEN=1 instance: 1024 frames with tlast wrap the counter
    b_bad = 0;
    for (int i = 1; i <= 1024; i++) begin
      b_mon_tvalid = 1'b1; b_mon_tready = 1'b1; b_mon_tlast = 1'b1;
      tick();
      if (b_ev_unexp || b_ev_miss || b_frame_active || !b_cfg_tready) b_bad++;
      if (i == 1023) chk("fl1_cnt_1023", 32'(b_frame_cnt), 32'd1023);
    end
    chk("fl1_wrap", 32'(b_frame_cnt), 32'h0);
    chk("fl1_clean", b_bad, 0);
    b_mon_tlast = 1'b0;
    tick();
    b_mon_tvalid = 1'b0;
    chk("fl1_miss", 32'(b_ev_miss), 32'h1);
    chk("fl1_miss_cnt", 32'(b_frame_cnt), 32'h1);
    chk("fl1_miss_idle", 32'(b_frame_active), 32'h0);
    tick();
    chk("fl1_miss_drop", 32'(b_ev_miss), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/axis_fft_config_sink.md
Name: axis_fft_config_sink

Overview:
- AXI4-Stream slave for an FFT configuration channel; the receiving end of the per-core config word broadcast.
- Accepts config words only between frames, holds the active direction and scale schedule, and tracks frame boundaries by observing the core's data-input handshake.
- Sits in front of each FFT/IFFT datapath. Also serves as the behavioural config-port model in benches.

Parameters:
- CFG_W, 16, config tdata width. Bit 0 is FWD_INV (1 = forward); bits CFG_W-1:1 are SCALE_SCH.
- FRAME_LEN, 512, data beats per FFT frame. Range 1..2^CNT_W.
- CNT_W, 10, width of the beat counter and frame counter.
- RESET_CFG, 16'h0001, config register value after reset.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  asynchronous reset, active-high.
- s_axis_config_tdata  in  CFG_W  config word.
- s_axis_config_tvalid  in  1  config word valid.
- s_axis_config_tready  out  1  sink can accept a config word.
- mon_tvalid  in  1  observed data-channel tvalid.
- mon_tready  in  1  observed data-channel tready.
- mon_tlast  in  1  observed data-channel tlast.
- cfg_fwd_inv  out  1  active transform direction.
- cfg_scale_sch  out  CFG_W-1  active scale schedule.
- cfg_update  out  1  one-cycle pulse after a config word is latched.
- frame_active  out  1  a frame is in progress.
- event_tlast_unexpected  out  1  one-cycle pulse when tlast arrives before beat FRAME_LEN.
- event_tlast_missing  out  1  one-cycle pulse when beat FRAME_LEN arrives without tlast.
- frame_cnt  out  CNT_W  completed frames, wrapping.

Behaviour:
- Reset (asynchronous, takes effect immediately): state=IDLE, cfg register=RESET_CFG (cfg_fwd_inv=1, cfg_scale_sch=0), cfg_update=0, frame_active=0, both event outputs=0, frame_cnt=0, beat counter=0. s_axis_config_tready=0 while areset=1.
- Beat definition: a beat occurs when mon_tvalid && mon_tready. Config handshake definition: s_axis_config_tvalid && s_axis_config_tready.
- s_axis_config_tready = (state==IDLE) && !areset. It is combinational from registered state and never depends on tvalid.
- Config latch: on a config handshake, cfg_fwd_inv<=tdata[0] and cfg_scale_sch<=tdata[CFG_W-1:1]. cfg_update is registered high for exactly the following cycle.
- Back-to-back config words in IDLE: each is accepted, the last one wins, and cfg_update is asserted for each.
- State IDLE:
  - A beat with FRAME_LEN>1 → ACTIVE, beat counter=1, frame_active=1 from the next cycle.
  - If mon_tlast is set on that beat: event_tlast_unexpected pulses, frame_cnt increments, and the state stays IDLE.
  - With FRAME_LEN==1: a beat with tlast is a normal end (frame_cnt+1). A beat without tlast pulses event_tlast_missing and frame_cnt+1. The state stays IDLE in both cases.
- State ACTIVE: tready=0, so config words stall with tvalid and tdata held by the master. Each beat increments the beat counter. The frame ends on the beat where count+1==FRAME_LEN or mon_tlast=1:
  - count+1==FRAME_LEN with tlast: normal end.
  - tlast with count+1<FRAME_LEN: event_tlast_unexpected.
  - count+1==FRAME_LEN without tlast: event_tlast_missing; the frame is still terminated.
  - On any end: frame_cnt+1 (wraps 2^CNT_W-1→0), beat counter←0, state←IDLE, frame_active=0 next cycle.
- Simultaneous config handshake and first beat in IDLE: the config is latched on the same edge and governs the frame that starts.
- Cycles with mon_tvalid=1 and mon_tready=0 are not beats and change nothing.
- Reset mid-frame: the frame is abandoned, no event pulses, frame_cnt=0, and the config returns to RESET_CFG.
- Latency:
  - Config handshake → cfg_* outputs: 1 cycle.
  - Config handshake → cfg_update: 1 cycle.
  - Terminating beat → frame_cnt / event outputs / frame_active drop: 1 cycle.

Test Plan:
- Reset then idle → cfg_fwd_inv=1, cfg_scale_sch=0, tready=1, frame_cnt=0. Raise areset mid-frame at beat 100 → all outputs return to reset values within the same cycle.
- Send config 16'h0000 in IDLE → next cycle cfg_fwd_inv=0, cfg_update high for 1 cycle. Then send 16'h00AB → cfg_scale_sch=15'h0055, cfg_fwd_inv=1.
- Stream 512 beats with tlast on beat 512 and random mon_tready gaps → frame_active high from beat 1+1 cycle, frame_cnt=1, no events. Config presented at beat 10 stays stalled until the cycle after beat 512, then is accepted.
- Stream with tlast on beat 300 → event_tlast_unexpected pulses once, frame_cnt+1, IDLE. Stream 512 beats without tlast → event_tlast_missing pulses once on the cycle after beat 512.
- Config handshake and first beat on the same edge with tdata=16'h0000 → cfg_fwd_inv=0 next cycle, frame_active=1.
- Run 1024 back-to-back frames (CNT_W=10) → frame_cnt wraps 1023→0. Rerun with FRAME_LEN=1: each beat with tlast counts a frame with no events, and the state never leaves IDLE.
